multicycle_control_unit: RTL and testbench
==========================================

Name: multicycle_control_unit

Overview:
Multi-cycle main control FSM for the RV32I core. It is the sequential successor to the single-cycle opcode decoder. It sequences fetch, decode, execute, memory and writeback over several cycles and drives every datapath enable and mux select. Instruction and data memory share one port, with a ready handshake and a bounded wait timeout. It covers R, I-ALU, load, store, branch, JAL, JALR, LUI and AUIPC.

Parameters:
- ALUOP_W, 2: width of alu_op (≥2); bits above [1:0] are driven 0.
- WAIT_MAX, 15: max cycles a memory state waits for mem_ready before trapping (≥1).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous reset, active-high.
- opcode  in  7  instruction[6:0] from the IR; sampled in DECODE.
- branch_taken  in  1  datapath funct3 comparison result.
- mem_ready  in  1  shared memory port completion.
- pc_write  out  1  PC register enable.
- pc_src  out  2  PC source: 0 ALU result, 1 ALUOut, 2 ALU result with bit0 cleared.
- ir_write  out  1  instruction register enable.
- i_or_d  out  1  memory address select: 0 PC, 1 ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- reg_write  out  1  register file write enable.
- wb_sel  out  2  writeback source: 0 ALUOut, 1 MDR, 2 PC+4 (old PC).
- alu_src_a  out  2  ALU A: 0 PC, 1 rs1, 2 zero.
- alu_src_b  out  2  ALU B: 0 rs2, 1 const 4, 2 imm.
- alu_op  out  ALUOP_W  0 add, 1 sub/compare, 2 R-funct, 3 I-funct.
- trap  out  1  sticky; illegal opcode or memory timeout.
- state_o  out  4  current state encoding, for debug.

Behaviour:
- State register resets asynchronously to IDLE; the wait counter resets to 0.
- Outputs are Moore-decoded from state. Exceptions: pc_write and ir_write in FETCH are qualified by mem_ready; pc_write in BRANCH equals branch_taken.
- IDLE: all outputs 0. Moves to FETCH on the first clock edge after rst deasserts. While rst is high, all outputs are 0.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=1, alu_op=0, pc_src=0. Holds until mem_ready; on mem_ready asserts ir_write and pc_write and moves to DECODE.
- DECODE: alu_src_a=0, alu_src_b=2, alu_op=0, so the branch/JAL target lands in ALUOut. Next state by opcode:
  - 0110011 → EXEC_R
  - 0010011 → EXEC_I
  - 0000011 or 0100011 → MEM_ADDR
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 1100111 → JALR
  - 0110111 → LUI (a=2, b=2)
  - 0010111 → AUIPC (a=0, b=2)
  - any other opcode → TRAP
- EXEC_R (a=1, b=0, op=2) and EXEC_I (a=1, b=2, op=3) → ALU_WB.
- LUI and AUIPC → ALU_WB.
- ALU_WB: reg_write=1, wb_sel=0 → FETCH.
- MEM_ADDR: a=1, b=2, op=0. Goes to MEM_RD if opcode[5]=0, else MEM_WR.
- MEM_RD: mem_read=1, i_or_d=1; waits for mem_ready, then → MEM_WB.
- MEM_WB: reg_write=1, wb_sel=1 → FETCH.
- MEM_WR: mem_write=1, i_or_d=1; waits for mem_ready, then → FETCH.
- BRANCH: a=1, b=0, op=1, pc_src=1, pc_write=branch_taken → FETCH.
- JAL: pc_write=1, pc_src=1, reg_write=1, wb_sel=2 → FETCH.
- JALR: a=1, b=2, op=0, pc_src=2, pc_write=1, reg_write=1, wb_sel=2 → FETCH.
- Wait counter:
  - Increments each cycle in FETCH, MEM_RD or MEM_WR while mem_ready=0.
  - Clears on any state change.
  - If it reaches WAIT_MAX with mem_ready still 0, the next state is TRAP.
  - mem_ready arriving on the same cycle the counter hits WAIT_MAX wins: the state proceeds normally.
- TRAP: all outputs 0 except trap=1. Terminal until rst.
- opcode is sampled only in DECODE and MEM_ADDR; changes in other states are ignored.
- Latency in cycles, including FETCH at zero wait: R/I/LUI/AUIPC 4, load 5, store 4, branch 3, JAL/JALR 3.

Optional Feature:
MCU_PERF_COUNTERS_EN
- With the macro defined: adds outputs cycle_cnt[31:0] and instret[31:0], both reset to 0.
  - cycle_cnt increments every cycle outside IDLE and TRAP.
  - instret increments on every transition into FETCH from a non-IDLE state.
  - Both wrap at 2^32.
- Without the macro: the ports and logic are absent.

Decomposition:
- Shared package rv_ctrl_pkg holds:
  - opcode constants;
  - state enum (4-bit);
  - alu_op, pc_src, wb_sel, alu_src_a and alu_src_b encodings.
- One sub-module is natural: mcu_output_decode, a pure combinational state→control-word decoder. The FSM, wait counter and counters stay in the top module.

Test Plan:
- Reset release with opcode 0110011 and mem_ready=1 → IDLE, FETCH (ir_write=1, pc_write=1), DECODE, EXEC_R (alu_op=2), ALU_WB (reg_write=1, wb_sel=0), FETCH; 5 cycles after IDLE.
- Load 0000011 with mem_ready low 3 cycles in MEM_RD → mem_read and i_or_d held 4 cycles, then MEM_WB with wb_sel=1.
- Branch 1100011: branch_taken=1 → pc_write=1, pc_src=1 in BRANCH; branch_taken=0 → pc_write=0; both return to FETCH.
- Opcode 1111111 in DECODE → TRAP, trap=1, all other outputs 0 for 20 cycles; rst pulse → IDLE, trap=0.
- Store with mem_ready held 0 and WAIT_MAX=15 → TRAP after 15 wait cycles. Separate case: mem_ready=1 exactly on the 15th cycle → FETCH, no trap.
- Async rst asserted mid-MEM_WR (between edges) → outputs 0 immediately, state_o=IDLE. With MCU_PERF_COUNTERS_EN, instret=0 after reset.

Source files
------------

// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle control unit: opcodes, FSM states,
// datapath select encodings and the control-word struct.
package rv_ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_EXEC_I   = 4'd4,
    S_LUI      = 4'd5,
    S_AUIPC    = 4'd6,
    S_ALU_WB   = 4'd7,
    S_MEM_ADDR = 4'd8,
    S_MEM_RD   = 4'd9,
    S_MEM_WB   = 4'd10,
    S_MEM_WR   = 4'd11,
    S_BRANCH   = 4'd12,
    S_JAL      = 4'd13,
    S_JALR     = 4'd14,
    S_TRAP     = 4'd15
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD    = 2'd0,
    ALU_SUB    = 2'd1,
    ALU_RFUNCT = 2'd2,
    ALU_IFUNCT = 2'd3
  } alu_op_t;

  typedef enum logic [1:0] {
    PC_SRC_ALU    = 2'd0,
    PC_SRC_ALUOUT = 2'd1,
    PC_SRC_JALR   = 2'd2
  } pc_src_t;

  typedef enum logic [1:0] {
    WB_ALUOUT = 2'd0,
    WB_MDR    = 2'd1,
    WB_PC4    = 2'd2
  } wb_sel_t;

  typedef enum logic [1:0] {
    SRC_A_PC   = 2'd0,
    SRC_A_RS1  = 2'd1,
    SRC_A_ZERO = 2'd2
  } src_a_t;

  typedef enum logic [1:0] {
    SRC_B_RS2  = 2'd0,
    SRC_B_FOUR = 2'd1,
    SRC_B_IMM  = 2'd2
  } src_b_t;

  typedef struct packed {
    logic    pc_write;
    pc_src_t pc_src;
    logic    ir_write;
    logic    i_or_d;
    logic    mem_read;
    logic    mem_write;
    logic    reg_write;
    wb_sel_t wb_sel;
    src_a_t  alu_src_a;
    src_b_t  alu_src_b;
    alu_op_t alu_op;
    logic    trap;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '0;

endpackage

// File: rtl/mcu_output_decode.sv
// Combinational state -> control-word decoder for the multi-cycle control unit.
// Moore outputs, except the FETCH enables (mem_ready) and BRANCH pc_write (branch_taken).
module mcu_output_decode
  import rv_ctrl_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  input  logic   branch_taken,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = CTRL_NONE;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRC_B_FOUR;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      // PC + imm computed here so branch/JAL targets are already in ALUOut
      S_DECODE: ctrl.alu_src_b = SRC_B_IMM;
      S_EXEC_R: begin
        ctrl.alu_src_a = SRC_A_RS1;
        ctrl.alu_op    = ALU_RFUNCT;
      end
      S_EXEC_I: begin
        ctrl.alu_src_a = SRC_A_RS1;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.alu_op    = ALU_IFUNCT;
      end
      S_LUI: begin
        ctrl.alu_src_a = SRC_A_ZERO;
        ctrl.alu_src_b = SRC_B_IMM;
      end
      S_AUIPC:  ctrl.alu_src_b = SRC_B_IMM;
      S_ALU_WB: ctrl.reg_write = 1'b1;
      S_MEM_ADDR: begin
        ctrl.alu_src_a = SRC_A_RS1;
        ctrl.alu_src_b = SRC_B_IMM;
      end
      S_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.wb_sel    = WB_MDR;
      end
      S_MEM_WR: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a = SRC_A_RS1;
        ctrl.alu_op    = ALU_SUB;
        ctrl.pc_src    = PC_SRC_ALUOUT;
        ctrl.pc_write  = branch_taken;
      end
      S_JAL: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_src    = PC_SRC_ALUOUT;
        ctrl.reg_write = 1'b1;
        ctrl.wb_sel    = WB_PC4;
      end
      S_JALR: begin
        ctrl.alu_src_a = SRC_A_RS1;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.pc_src    = PC_SRC_JALR;
        ctrl.pc_write  = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.wb_sel    = WB_PC4;
      end
      S_TRAP:  ctrl.trap = 1'b1;
      default: ctrl = CTRL_NONE;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// RV32I multi-cycle main control FSM with shared-memory wait timeout and sticky trap.
// Optional MCU_PERF_COUNTERS_EN adds cycle_cnt / instret outputs.
module multicycle_control_unit
  import rv_ctrl_pkg::*;
#(
  parameter int ALUOP_W  = 2,
  parameter int WAIT_MAX = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [6:0]         opcode,
  input  logic               branch_taken,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic [1:0]         pc_src,
  output logic               ir_write,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               reg_write,
  output logic [1:0]         wb_sel,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               trap,
  output logic [3:0]         state_o
`ifdef MCU_PERF_COUNTERS_EN
  ,
  output logic [31:0]        cycle_cnt,
  output logic [31:0]        instret
`endif
);

  localparam int WAIT_W = $clog2(WAIT_MAX + 1);

  state_t            state_reg;
  state_t            state_next;
  logic [WAIT_W-1:0] wait_cnt_reg;
  logic              waiting;
  logic              timeout;
  ctrl_t             ctrl;

  assign waiting = ((state_reg == S_FETCH) || (state_reg == S_MEM_RD) ||
                    (state_reg == S_MEM_WR)) && !mem_ready;
  // This cycle is the WAIT_MAX-th without mem_ready; a late mem_ready still wins.
  assign timeout = waiting && (wait_cnt_reg >= WAIT_W'(WAIT_MAX - 1));

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:   state_next = S_FETCH;
      S_FETCH:  if (mem_ready) state_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_R:               state_next = S_EXEC_R;
          OP_I:               state_next = S_EXEC_I;
          OP_LOAD, OP_STORE:  state_next = S_MEM_ADDR;
          OP_BRANCH:          state_next = S_BRANCH;
          OP_JAL:             state_next = S_JAL;
          OP_JALR:            state_next = S_JALR;
          OP_LUI:             state_next = S_LUI;
          OP_AUIPC:           state_next = S_AUIPC;
          default:            state_next = S_TRAP;
        endcase
      end
      S_EXEC_R, S_EXEC_I, S_LUI, S_AUIPC: state_next = S_ALU_WB;
      S_ALU_WB, S_MEM_WB, S_BRANCH, S_JAL, S_JALR: state_next = S_FETCH;
      S_MEM_ADDR: state_next = opcode[5] ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: if (mem_ready) state_next = S_MEM_WB;
      S_MEM_WR: if (mem_ready) state_next = S_FETCH;
      S_TRAP:   state_next = S_TRAP;
      default:  state_next = S_TRAP;
    endcase
    if (timeout) state_next = S_TRAP;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      wait_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_next != state_reg) begin
        wait_cnt_reg <= '0;
      end else if (waiting) begin
        wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
      end
    end
  end

`ifdef MCU_PERF_COUNTERS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt <= '0;
      instret   <= '0;
    end else begin
      if ((state_reg != S_IDLE) && (state_reg != S_TRAP)) begin
        cycle_cnt <= cycle_cnt + 32'd1;
      end
      // Every return to FETCH retires exactly one instruction
      if ((state_next == S_FETCH) && (state_reg != S_FETCH) && (state_reg != S_IDLE)) begin
        instret <= instret + 32'd1;
      end
    end
  end
`endif

  mcu_output_decode u_output_decode (
    .state        (state_reg),
    .mem_ready    (mem_ready),
    .branch_taken (branch_taken),
    .ctrl         (ctrl)
  );

  assign pc_write  = ctrl.pc_write;
  assign pc_src    = ctrl.pc_src;
  assign ir_write  = ctrl.ir_write;
  assign i_or_d    = ctrl.i_or_d;
  assign mem_read  = ctrl.mem_read;
  assign mem_write = ctrl.mem_write;
  assign reg_write = ctrl.reg_write;
  assign wb_sel    = ctrl.wb_sel;
  assign alu_src_a = ctrl.alu_src_a;
  assign alu_src_b = ctrl.alu_src_b;
  assign alu_op    = ALUOP_W'(ctrl.alu_op);
  assign trap      = ctrl.trap;
  assign state_o   = state_reg;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: per-cycle stimulus/expected-state
// steps, expected control words queued at drive time and checked on the falling edge.
module tb_multicycle_control_unit;
  import rv_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  opcode;
  logic        branch_taken;
  logic        mem_ready;
  logic        pc_write, ir_write, i_or_d, mem_read, mem_write, reg_write, trap;
  logic [1:0]  pc_src, wb_sel, alu_src_a, alu_src_b, alu_op;
  logic [3:0]  state_o;
`ifdef MCU_PERF_COUNTERS_EN
  logic [31:0] cycle_cnt, instret;
`endif

  multicycle_control_unit #(.ALUOP_W(2), .WAIT_MAX(15)) dut (
    .clk          (clk),
    .rst          (rst),
    .opcode       (opcode),
    .branch_taken (branch_taken),
    .mem_ready    (mem_ready),
    .pc_write     (pc_write),
    .pc_src       (pc_src),
    .ir_write     (ir_write),
    .i_or_d       (i_or_d),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .reg_write    (reg_write),
    .wb_sel       (wb_sel),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .alu_op       (alu_op),
    .trap         (trap),
    .state_o      (state_o)
`ifdef MCU_PERF_COUNTERS_EN
    ,
    .cycle_cnt    (cycle_cnt),
    .instret      (instret)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] op;
    logic       bt;
    logic       mr;
    state_t     st;
  } step_t;

  typedef struct packed {
    state_t      st;
    logic [17:0] ctrl;
  } exp_t;

  step_t stim_q[$];
  exp_t  exp_q[$];
  exp_t  e;
  int    tests_run = 0;
  int    tests_failed = 0;

  logic [17:0] obs_ctrl;
  assign obs_ctrl = {pc_write, pc_src, ir_write, i_or_d, mem_read, mem_write,
                     reg_write, wb_sel, alu_src_a, alu_src_b, alu_op, trap};

  // Reference control word written straight from the state/output table.
  function automatic logic [17:0] model(state_t s, logic mr, logic bt);
    logic       pw, irw, iod, mrd, mwr, rw, tr;
    logic [1:0] ps, wb, a, b, op;
    {pw, irw, iod, mrd, mwr, rw, tr} = 7'd0;
    {ps, wb, a, b, op} = 10'd0;
    case (s)
      S_FETCH:    begin mrd = 1'b1; b = 2'd1; pw = mr; irw = mr; end
      S_DECODE:   b = 2'd2;
      S_EXEC_R:   begin a = 2'd1; op = 2'd2; end
      S_EXEC_I:   begin a = 2'd1; b = 2'd2; op = 2'd3; end
      S_LUI:      begin a = 2'd2; b = 2'd2; end
      S_AUIPC:    b = 2'd2;
      S_ALU_WB:   rw = 1'b1;
      S_MEM_ADDR: begin a = 2'd1; b = 2'd2; end
      S_MEM_RD:   begin mrd = 1'b1; iod = 1'b1; end
      S_MEM_WB:   begin rw = 1'b1; wb = 2'd1; end
      S_MEM_WR:   begin mwr = 1'b1; iod = 1'b1; end
      S_BRANCH:   begin a = 2'd1; op = 2'd1; ps = 2'd1; pw = bt; end
      S_JAL:      begin pw = 1'b1; ps = 2'd1; rw = 1'b1; wb = 2'd2; end
      S_JALR:     begin a = 2'd1; b = 2'd2; ps = 2'd2; pw = 1'b1; rw = 1'b1; wb = 2'd2; end
      S_TRAP:     tr = 1'b1;
      default:    ;
    endcase
    return {pw, ps, irw, iod, mrd, mwr, rw, wb, a, b, op, tr};
  endfunction

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic logic [6:0] rnd_op();
    return 7'($urandom);
  endfunction

  task automatic push_step(logic [6:0] op, logic bt, logic mr, state_t st);
    stim_q.push_back('{op: op, bt: bt, mr: mr, st: st});
  endtask

  // Drive the next step's inputs and queue the expected DUT response for this cycle.
  task automatic apply_step();
    step_t s;
    s = stim_q.pop_front();
    opcode       = s.op;
    branch_taken = s.bt;
    mem_ready    = s.mr;
    exp_q.push_back('{st: s.st, ctrl: model(s.st, s.mr, s.bt)});
  endtask

  // Called at posedge+1; releases reset so the next edge enters FETCH.
  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    int n = 0;
    opcode = OP_R; branch_taken = 1'b1; mem_ready = 1'b1;
    exp_q.push_back('{st: S_IDLE, ctrl: 18'd0});
    @(negedge clk);
    e = exp_q.pop_front();
    tests_run++;
    if (state_o !== e.st || obs_ctrl !== e.ctrl) begin
      tests_failed++;
      $display("FAIL reset_held: state=%0d ctrl=%b, expected state=%0d ctrl=%b", state_o, obs_ctrl, e.st, e.ctrl);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    push_step(OP_R, 1'b0, 1'b1, S_IDLE);
    push_step(OP_R, 1'b0, 1'b1, S_FETCH);
    push_step(OP_R, 1'b0, 1'b1, S_DECODE);
    push_step(OP_R, 1'b0, 1'b1, S_EXEC_R);
    push_step(OP_R, 1'b0, 1'b1, S_ALU_WB);
    push_step(OP_R, 1'b0, 1'b1, S_FETCH);
    while (stim_q.size() != 0) begin
      apply_step();
      @(negedge clk);
      e = exp_q.pop_front();
      tests_run++;
      if (state_o !== e.st || obs_ctrl !== e.ctrl) begin
        tests_failed++;
        $display("FAIL r_type[%0d]: state=%0d ctrl=%b, expected state=%0d ctrl=%b", n, state_o, obs_ctrl, e.st, e.ctrl);
      end
      n++;
      @(posedge clk); #1;
    end
`ifdef MCU_PERF_COUNTERS_EN
    tests_run++;
    if (instret !== 32'd1 || cycle_cnt !== 32'd5) begin
      tests_failed++;
      $display("FAIL perf_after_r: instret=%0d cycle_cnt=%0d, expected instret=1 cycle_cnt=5", instret, cycle_cnt);
    end
`endif
  endtask

  task automatic test_load_store();
    int n = 0;
    do_reset();
    push_step(OP_LOAD, 1'b0, 1'b1, S_IDLE);
    push_step(OP_LOAD, 1'b0, 1'b1, S_FETCH);
    push_step(OP_LOAD, 1'b0, 1'b1, S_DECODE);
    push_step(OP_LOAD, 1'b0, 1'b0, S_MEM_ADDR);
    for (int i = 0; i < 3; i++) push_step(OP_LOAD, 1'b0, 1'b0, S_MEM_RD);
    push_step(OP_LOAD, 1'b0, 1'b1, S_MEM_RD);
    push_step(OP_LOAD, 1'b0, 1'b1, S_MEM_WB);
    push_step(OP_STORE, 1'b0, 1'b1, S_FETCH);
    push_step(OP_STORE, 1'b0, 1'b1, S_DECODE);
    push_step(OP_STORE, 1'b0, 1'b0, S_MEM_ADDR);
    push_step(OP_STORE, 1'b0, 1'b1, S_MEM_WR);
    push_step(OP_STORE, 1'b0, 1'b1, S_FETCH);
    while (stim_q.size() != 0) begin
      apply_step();
      @(negedge clk);
      e = exp_q.pop_front();
      tests_run++;
      if (state_o !== e.st || obs_ctrl !== e.ctrl) begin
        tests_failed++;
        $display("FAIL load_store[%0d]: state=%0d ctrl=%b, expected state=%0d ctrl=%b", n, state_o, obs_ctrl, e.st, e.ctrl);
      end
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch();
    int n = 0;
    do_reset();
    push_step(OP_BRANCH, 1'b0, 1'b1, S_IDLE);
    push_step(OP_BRANCH, 1'b0, 1'b1, S_FETCH);
    push_step(OP_BRANCH, 1'b0, 1'b1, S_DECODE);
    push_step(OP_BRANCH, 1'b1, 1'b1, S_BRANCH);
    push_step(OP_BRANCH, 1'b1, 1'b1, S_FETCH);
    push_step(OP_BRANCH, 1'b1, 1'b1, S_DECODE);
    push_step(OP_BRANCH, 1'b0, 1'b1, S_BRANCH);
    push_step(OP_BRANCH, 1'b0, 1'b1, S_FETCH);
    while (stim_q.size() != 0) begin
      apply_step();
      @(negedge clk);
      e = exp_q.pop_front();
      tests_run++;
      if (state_o !== e.st || obs_ctrl !== e.ctrl) begin
        tests_failed++;
        $display("FAIL branch[%0d]: state=%0d ctrl=%b, expected state=%0d ctrl=%b", n, state_o, obs_ctrl, e.st, e.ctrl);
      end
      n++;
      @(posedge clk); #1;
    end
  endtask

  // Opcode is randomised outside DECODE/MEM_ADDR, where it must be ignored.
  task automatic test_back_to_back();
    int n = 0;
    do_reset();
    push_step(rnd_op(), rb(), rb(), S_IDLE);
    push_step(rnd_op(), rb(), 1'b0, S_FETCH);
    push_step(rnd_op(), rb(), 1'b1, S_FETCH);
    push_step(OP_JAL,   rb(), rb(), S_DECODE);
    push_step(rnd_op(), rb(), rb(), S_JAL);
    push_step(rnd_op(), rb(), 1'b1, S_FETCH);
    push_step(OP_JALR,  rb(), rb(), S_DECODE);
    push_step(rnd_op(), rb(), rb(), S_JALR);
    push_step(rnd_op(), rb(), 1'b1, S_FETCH);
    push_step(OP_I,     rb(), rb(), S_DECODE);
    push_step(rnd_op(), rb(), rb(), S_EXEC_I);
    push_step(rnd_op(), rb(), rb(), S_ALU_WB);
    push_step(rnd_op(), rb(), 1'b1, S_FETCH);
    push_step(OP_LUI,   rb(), rb(), S_DECODE);
    push_step(rnd_op(), rb(), rb(), S_LUI);
    push_step(rnd_op(), rb(), rb(), S_ALU_WB);
    push_step(rnd_op(), rb(), 1'b1, S_FETCH);
    push_step(OP_AUIPC, rb(), rb(), S_DECODE);
    push_step(rnd_op(), rb(), rb(), S_AUIPC);
    push_step(rnd_op(), rb(), rb(), S_ALU_WB);
    push_step(rnd_op(), rb(), 1'b1, S_FETCH);
    while (stim_q.size() != 0) begin
      apply_step();
      @(negedge clk);
      e = exp_q.pop_front();
      tests_run++;
      if (state_o !== e.st || obs_ctrl !== e.ctrl) begin
        tests_failed++;
        $display("FAIL back_to_back[%0d]: state=%0d ctrl=%b, expected state=%0d ctrl=%b", n, state_o, obs_ctrl, e.st, e.ctrl);
      end
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal_trap();
    int n = 0;
    do_reset();
    push_step(7'h7F, 1'b0, 1'b1, S_IDLE);
    push_step(7'h7F, 1'b0, 1'b1, S_FETCH);
    push_step(7'h7F, 1'b0, 1'b1, S_DECODE);
    for (int i = 0; i < 20; i++) push_step(rnd_op(), rb(), rb(), S_TRAP);
    while (stim_q.size() != 0) begin
      apply_step();
      @(negedge clk);
      e = exp_q.pop_front();
      tests_run++;
      if (state_o !== e.st || obs_ctrl !== e.ctrl) begin
        tests_failed++;
        $display("FAIL illegal_trap[%0d]: state=%0d ctrl=%b, expected state=%0d ctrl=%b", n, state_o, obs_ctrl, e.st, e.ctrl);
      end
      n++;
      @(posedge clk); #1;
    end
    rst = 1'b1;
    exp_q.push_back('{st: S_IDLE, ctrl: 18'd0});
    #2;
    e = exp_q.pop_front();
    tests_run++;
    if (state_o !== e.st || obs_ctrl !== e.ctrl) begin
      tests_failed++;
      $display("FAIL trap_clear: state=%0d ctrl=%b, expected state=%0d ctrl=%b", state_o, obs_ctrl, e.st, e.ctrl);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_timeout();
    int n = 0;
    do_reset();
    push_step(OP_STORE, 1'b0, 1'b1, S_IDLE);
    push_step(OP_STORE, 1'b0, 1'b1, S_FETCH);
    push_step(OP_STORE, 1'b0, 1'b1, S_DECODE);
    push_step(OP_STORE, 1'b0, 1'b0, S_MEM_ADDR);
    for (int i = 0; i < 14; i++) push_step(OP_STORE, 1'b0, 1'b0, S_MEM_WR);
    push_step(OP_STORE, 1'b0, 1'b1, S_MEM_WR);
    push_step(OP_STORE, 1'b0, 1'b1, S_FETCH);
    push_step(OP_STORE, 1'b0, 1'b1, S_DECODE);
    push_step(OP_STORE, 1'b0, 1'b0, S_MEM_ADDR);
    for (int i = 0; i < 15; i++) push_step(OP_STORE, 1'b0, 1'b0, S_MEM_WR);
    push_step(OP_STORE, 1'b0, 1'b1, S_TRAP);
    push_step(OP_STORE, 1'b0, 1'b1, S_TRAP);
    while (stim_q.size() != 0) begin
      apply_step();
      @(negedge clk);
      e = exp_q.pop_front();
      tests_run++;
      if (state_o !== e.st || obs_ctrl !== e.ctrl) begin
        tests_failed++;
        $display("FAIL timeout[%0d]: state=%0d ctrl=%b, expected state=%0d ctrl=%b", n, state_o, obs_ctrl, e.st, e.ctrl);
      end
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_async_reset();
    int n = 0;
    do_reset();
    push_step(OP_STORE, 1'b0, 1'b1, S_IDLE);
    push_step(OP_STORE, 1'b0, 1'b1, S_FETCH);
    push_step(OP_STORE, 1'b0, 1'b1, S_DECODE);
    push_step(OP_STORE, 1'b0, 1'b0, S_MEM_ADDR);
    push_step(OP_STORE, 1'b0, 1'b0, S_MEM_WR);
    while (stim_q.size() != 0) begin
      apply_step();
      @(negedge clk);
      e = exp_q.pop_front();
      tests_run++;
      if (state_o !== e.st || obs_ctrl !== e.ctrl) begin
        tests_failed++;
        $display("FAIL async_pre[%0d]: state=%0d ctrl=%b, expected state=%0d ctrl=%b", n, state_o, obs_ctrl, e.st, e.ctrl);
      end
      n++;
      if (stim_q.size() != 0) begin
        @(posedge clk); #1;
      end
    end
`ifdef MCU_PERF_COUNTERS_EN
    tests_run++;
    if (cycle_cnt !== 32'd3) begin
      tests_failed++;
      $display("FAIL perf_cycles_mem_wr: cycle_cnt=%0d, expected 3", cycle_cnt);
    end
`endif
    #2;
    rst = 1'b1;
    exp_q.push_back('{st: S_IDLE, ctrl: 18'd0});
    #1;
    e = exp_q.pop_front();
    tests_run++;
    if (state_o !== e.st || obs_ctrl !== e.ctrl) begin
      tests_failed++;
      $display("FAIL async_reset: state=%0d ctrl=%b, expected state=%0d ctrl=%b", state_o, obs_ctrl, e.st, e.ctrl);
    end
`ifdef MCU_PERF_COUNTERS_EN
    tests_run++;
    if (instret !== 32'd0 || cycle_cnt !== 32'd0) begin
      tests_failed++;
      $display("FAIL perf_reset: instret=%0d cycle_cnt=%0d, expected 0 and 0", instret, cycle_cnt);
    end
`endif
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    opcode = 7'd0;
    branch_taken = 1'b0;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_load_store();
    test_branch();
    test_back_to_back();
    test_illegal_trap();
    test_timeout();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
